// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi_lite_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Replace the bytes of old_data selected by strb with the matching bytes of
  // new_data. Works on the widest bus; callers size-cast in and out.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] new_data,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// NUM_REGS x DATA_WIDTH register storage: one strobed write port, one
// asynchronous read port. Reads see the value before a same-edge write.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Clear everything on reset, otherwise merge the strobed bytes into one word
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[widx]),
                                          MAX_DATA_WIDTH'(wdata),
                                          MAX_STRB_WIDTH'(wstrb)));
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder over a small register file. Independent write and read
// channels, at most one outstanding transaction on each.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both 1. Our valid outputs (bvalid, rvalid) stay high and
// their payload stays stable until the matching ready is seen; our ready
// outputs are decoded from state and held flags only, never from inputs.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);

  // In range when the word address (addr >> ADDR_LSB) is below NUM_REGS
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (ADDR_LSB + IDX_W)) == '0;
  endfunction

  // ---------------- write channel ----------------
  wr_state_t             wr_state, wr_state_nxt;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  resp_t                 bresp_q;

  logic                  aw_hs, w_hs, commit, cmt_in_range;
  logic [ADDR_WIDTH-1:0] cmt_addr;
  logic [DATA_WIDTH-1:0] cmt_data;
  logic [STRB_W-1:0]     cmt_strb;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // A held beat wins over the live bus; a live handshake bypasses the latch
  assign cmt_addr     = aw_held ? aw_addr_q : awaddr;
  assign cmt_data     = w_held  ? w_data_q  : wdata;
  assign cmt_strb     = w_held  ? w_strb_q  : wstrb;
  assign commit       = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign cmt_in_range = addr_in_range(cmt_addr);

  // Write FSM state register
  always_ff @(posedge aclk) begin
    if (areset) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  // Write FSM next state: idle until a commit, then wait for the B handshake
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_state_nxt = WR_RESP;
      WR_RESP: if (bready) wr_state_nxt = WR_IDLE;
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write FSM outputs: readies only while idle and the latch is empty
  always_comb begin
    awready = !aw_held && (wr_state == WR_IDLE);
    wready  = !w_held  && (wr_state == WR_IDLE);
    bvalid  = (wr_state == WR_RESP);
  end

  // AW/W capture latches; a commit consumes both
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Write response code, fixed at commit and held through WR_RESP
  always_ff @(posedge aclk) begin
    if (areset)      bresp_q <= OKAY;
    else if (commit) bresp_q <= cmt_in_range ? OKAY : SLVERR;
  end

  assign bresp = bresp_q;

  // ---------------- read channel ----------------
  rd_state_t             rd_state, rd_state_nxt;
  logic                  ar_hs;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;

  assign ar_hs = arvalid && arready;

  // Read FSM state register
  always_ff @(posedge aclk) begin
    if (areset) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Read FSM next state: one AR accepted, then wait for the R handshake
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)  rd_state_nxt = RD_DATA;
      RD_DATA: if (rready) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    arready = (rd_state == RD_IDLE);
    rvalid  = (rd_state == RD_DATA);
  end

  // Capture read data at the AR handshake; the regfile still shows the
  // pre-write value if a write commits on the same edge
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      if (addr_in_range(araddr)) begin
        rdata_q <= rf_rdata;
        rresp_q <= OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= SLVERR;
      end
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

  axi_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .aclk   (aclk),
    .areset (areset),
    .we     (commit && cmt_in_range),
    .widx   (cmt_addr[ADDR_LSB +: IDX_W]),
    .wdata  (cmt_data),
    .wstrb  (cmt_strb),
    .ridx   (araddr[ADDR_LSB +: IDX_W]),
    .rdata  (rf_rdata)
  );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the slave.
module tb_axi_lite_slave_regs;

  localparam int TMO = 60;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  axi_lite_slave_regs #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Transaction view: pending AW/W beats, one outstanding B, one outstanding R.
  logic [31:0] m_regs [16];
  bit          m_aw_pend, m_w_pend, m_b_busy, m_r_busy;
  logic [31:0] m_aw_addr, m_w_data, m_r_data;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_b_resp, m_r_resp;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_aw_pend = 0; m_w_pend = 0; m_b_busy = 0; m_r_busy = 0;
    m_aw_addr = '0; m_w_data = '0; m_w_strb = '0;
    m_b_resp = 2'b00; m_r_resp = 2'b00; m_r_data = '0;
  endtask

  // Advance the model across the coming rising edge using the inputs now on the bus
  task automatic model_step();
    bit ex_awr, ex_wr, ex_arr;
    int ix;
    if (areset) begin
      model_reset();
      return;
    end
    ex_awr = !m_aw_pend && !m_b_busy;
    ex_wr  = !m_w_pend && !m_b_busy;
    ex_arr = !m_r_busy;
    // read sees the register contents before any write on this edge
    if (arvalid && ex_arr) begin
      if (araddr / 4 < 16) begin
        m_r_data = m_regs[araddr / 4];
        m_r_resp = 2'b00;
      end else begin
        m_r_data = '0;
        m_r_resp = 2'b10;
      end
      m_r_busy = 1;
    end else if (m_r_busy && rready) begin
      m_r_busy = 0;
    end
    if (m_b_busy) begin
      if (bready) m_b_busy = 0;
    end else begin
      if (awvalid && ex_awr) begin m_aw_pend = 1; m_aw_addr = awaddr; end
      if (wvalid && ex_wr)   begin m_w_pend = 1; m_w_data = wdata; m_w_strb = wstrb; end
      if (m_aw_pend && m_w_pend) begin
        if (m_aw_addr / 4 < 16) begin
          ix = int'(m_aw_addr / 4);
          for (int i = 0; i < 4; i++)
            if (m_w_strb[i]) m_regs[ix][i*8 +: 8] = m_w_data[i*8 +: 8];
          m_b_resp = 2'b00;
        end else begin
          m_b_resp = 2'b10;
        end
        m_b_busy = 1; m_aw_pend = 0; m_w_pend = 0;
      end
    end
  endtask

  initial model_reset();

  // ---------------- compare process ----------------
  always @(negedge aclk) begin
    if (mon_en) begin
      check("awready", awready, !m_aw_pend && !m_b_busy);
      check("wready", wready, !m_w_pend && !m_b_busy);
      check("arready", arready, !m_r_busy);
      check("bvalid", bvalid, m_b_busy);
      if (m_b_busy) check("bresp", bresp, m_b_resp);
      check("rvalid", rvalid, m_r_busy);
      if (m_r_busy) begin
        check("rdata", rdata, m_r_data);
        check("rresp", rresp, m_r_resp);
      end
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and finish 1 time unit after a rising edge.
  task automatic send_aw(input logic [31:0] a, input int dly);
    int n;
    repeat (dly) begin @(posedge aclk); #1; end
    awaddr = a; awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < TMO);
    if (!awready) timeout("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    repeat (dly) begin @(posedge aclk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!wready && n < TMO);
    if (!wready) timeout("w_handshake");
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly);
    int n;
    repeat (dly) begin @(posedge aclk); #1; end
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < TMO);
    if (!arready) timeout("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic recv_b(input int hold, output logic [1:0] resp);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bvalid && n < TMO);
    if (!bvalid) timeout("bvalid_wait");
    resp = bresp;
    repeat (hold + 1) begin @(posedge aclk); #1; end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic recv_r(input int hold, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (!rvalid && n < TMO);
    if (!rvalid) timeout("rvalid_wait");
    d = rdata; resp = rresp;
    repeat (hold + 1) begin @(posedge aclk); #1; end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output logic [1:0] resp);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    recv_b(b_hold, resp);
  endtask

  task automatic read_txn(input logic [31:0] a, input int ar_dly, input int r_hold,
                          output logic [31:0] d, output logic [1:0] resp);
    send_ar(a, ar_dly);
    recv_r(r_hold, d, resp);
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  resp, rresp_v;
    logic [31:0] d;
    int n;

    @(posedge aclk); #1;
    mon_en = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    #1;
    check("reset_awready", awready, 1);
    check("reset_wready", wready, 1);
    check("reset_arready", arready, 1);
    check("reset_bvalid", bvalid, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_bresp", bresp, 0);
    check("reset_rresp", rresp, 0);
    check("reset_rdata", rdata, 0);
    @(posedge aclk); #1;

    // AW and W together
    write_txn(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
    check("t1_bresp", resp, 2'b00);
    read_txn(32'h8, 0, 0, d, rresp_v);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", rresp_v, 2'b00);

    // W first, AW three cycles later, partial strobes
    write_txn(32'h8, 32'h11223344, 4'h5, 3, 0, 0, resp);
    check("t2_bresp", resp, 2'b00);
    read_txn(32'h8, 0, 0, d, rresp_v);
    check("t2_rdata", d, 32'hDE22BE44);

    // Out of range
    write_txn(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, resp);
    check("t3_bresp", resp, 2'b10);
    read_txn(32'h40, 0, 0, d, rresp_v);
    check("t3_rdata", d, 32'h0);
    check("t3_rresp", rresp_v, 2'b10);
    read_txn(32'h8, 0, 0, d, rresp_v);
    check("t3_reg2_kept", d, 32'hDE22BE44);

    // Back-pressure on B and R
    write_txn(32'h10, 32'h0BADF00D, 4'hF, 1, 2, 5, resp);
    check("t4_bresp", resp, 2'b00);
    read_txn(32'h10, 0, 5, d, rresp_v);
    check("t4_rdata", d, 32'h0BADF00D);

    // Write commit and AR on the same edge
    fork
      write_txn(32'h4, 32'hAAAA5555, 4'hF, 0, 0, 0, resp);
      read_txn(32'h4, 0, 0, d, rresp_v);
    join
    check("t5_rdata_prewrite", d, 32'h0);
    read_txn(32'h4, 0, 0, d, rresp_v);
    check("t5_rdata_after", d, 32'hAAAA5555);

    // Reset while a B response is pending
    fork
      send_aw(32'hC, 0);
      send_w(32'h12345678, 4'hF, 0);
    join
    n = 0;
    while (!bvalid && n < TMO) begin @(negedge aclk); n++; end
    if (!bvalid) timeout("t6_bvalid_wait");
    pulse_reset();
    check("t6_bvalid", bvalid, 0);
    check("t6_awready", awready, 1);
    check("t6_wready", wready, 1);

    // Reset with an AW held and a read response pending
    send_aw(32'h0, 0);
    send_ar(32'h8, 0);
    @(posedge aclk); #1;
    check("t7_aw_held", awready, 0);
    pulse_reset();
    check("t7_awready", awready, 1);
    check("t7_rvalid", rvalid, 0);
    check("t7_arready", arready, 1);
    for (int i = 0; i < 16; i++) begin
      read_txn(32'(i * 4), 0, 0, d, rresp_v);
      check($sformatf("t7_reg%0d_zero", i), d, 32'h0);
    end

    // Randomized independent write and read traffic
    fork
      begin
        logic [1:0] wr_resp;
        for (int k = 0; k < 60; k++) begin
          write_txn(32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)), $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), wr_resp);
        end
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_resp;
        for (int k = 0; k < 60; k++) begin
          read_txn(32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
                   $urandom_range(0, 3), $urandom_range(0, 3), rd_d, rd_resp);
        end
      end
    join

    // Final sweep so every register is compared against the model
    for (int i = 0; i < 16; i++) read_txn(32'(i * 4), 0, 0, d, rresp_v);

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
